// File: rtl/ofdm_pkg.sv
// Shared constants, FSM state and bin classification for the OFDM-256 subcarrier mapper.
package ofdm_pkg;
   localparam int N_FFT       = 256;
   localparam int N_DATA      = 192;
   localparam int N_USED_HALF = 100;

   localparam logic signed [7:0] F_FIRST = 8'(-N_USED_HALF);
   localparam logic signed [7:0] F_LAST  = 8'(N_USED_HALF);

   // Pilot bins in ascending frequency: f = -88, -63, -38, -13, 13, 38, 63, 88
   localparam logic [7:0] PILOT_BIN [8] = '{8'd168, 8'd193, 8'd218, 8'd243,
                                           8'd13,  8'd38,  8'd63,  8'd88};
   localparam logic [7:0] PILOT_GRP_A = 8'b1100_0101;
   localparam logic [7:0] PILOT_GRP_B = ~PILOT_GRP_A;

   typedef enum logic {FILL, DRAIN} state_t;
   typedef enum logic [2:0] {GUARD, DC, PILOT_A, PILOT_B, DATA} bin_class_t;

   function automatic bin_class_t bin_class(input logic [7:0] b);
      bin_class_t c;
      c = DATA;
      if (b == 8'd0)
         c = DC;
      else if (b > 8'(N_USED_HALF) && b < 8'(N_FFT - N_USED_HALF))
         c = GUARD;
      else
         for (int i = 0; i < 8; i++)
            if (b == PILOT_BIN[i]) begin
               if (PILOT_GRP_A[i])
                  c = PILOT_A;
               else if (PILOT_GRP_B[i])
                  c = PILOT_B;
            end
      return c;
   endfunction
endpackage

// File: rtl/pilot_prbs.sv
// Pilot polarity PRBS x^11+x^9+1; wk is valid for the whole current symbol.
// Reloads the seed on load, steps once per adv pulse.
module pilot_prbs #(
   parameter logic [10:0] INIT = 11'h7FF
) (
   input  logic CLK_I,
   input  logic RST_I,
   input  logic load,
   input  logic adv,
   output logic wk
);
   logic [10:0] r;

   assign wk = r[10] ^ r[8];

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I)
         r <= INIT;
      else if (load)
         r <= INIT;
      else if (adv)
         r <= {r[9:0], wk};
   end
endmodule

// File: rtl/subcarrier_map.sv
// Buffers 192 data subcarriers, then streams 256 IFFT bins with pilots, DC and guards inserted; bin 0 appears 2 cycles after the last input ACK.
// Downstream stall (STB_O & ~ACK_I) freezes DAT_O/STB_O; input is refused for the whole drain (single buffer).
module subcarrier_map
   import ofdm_pkg::*;
#(
   parameter logic signed [15:0] PILOT_AMP = 16'sd8192,
   parameter logic [10:0]        LFSR_INIT = 11'h7FF
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [31:0] DAT_I,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   output logic        ACK_O,
   output logic [31:0] DAT_O,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I
);
   localparam logic [15:0] AMP_POS = PILOT_AMP;
   localparam logic [15:0] AMP_NEG = -PILOT_AMP;

   state_t            state;
   logic signed [7:0] f_w;
   logic signed [7:0] f_nxt;
   logic [7:0]        wr_addr;
   logic [8:0]        b;
   logic              last_q;
   logic              cyc_q;
   logic              cyc_rise;
   logic              wk;
   logic              halt;
   logic              last_acc;
   logic [31:0]       bin_val;
   logic [31:0]       ram [N_FFT];

   assign ACK_O    = CYC_I & STB_I & WE_I & (state == FILL);
   assign WE_O     = STB_O;
   assign halt     = STB_O & ~ACK_I;
   assign last_acc = STB_O & ACK_I & last_q;
   assign cyc_rise = CYC_I & ~cyc_q;
   assign wr_addr  = $unsigned(f_w);

   pilot_prbs #(.INIT(LFSR_INIT)) u_prbs (
      .CLK_I (CLK_I),
      .RST_I (RST_I),
      .load  (cyc_rise),
      .adv   (last_acc),
      .wk    (wk)
   );

   // Pilots are never adjacent, so skipping one pilot or DC is always enough.
   always_comb begin
      f_nxt = f_w + 8'sd1;
      if (bin_class(f_nxt) inside {DC, PILOT_A, PILOT_B})
         f_nxt = f_w + 8'sd2;
   end

   always_ff @(posedge CLK_I) begin
      if (ACK_O)
         ram[wr_addr] <= DAT_I;
   end

   always_comb begin
      bin_val = '0;
      case (bin_class(b[7:0]))
         PILOT_A: bin_val = {16'h0000, wk ? AMP_NEG : AMP_POS};
         PILOT_B: bin_val = {16'h0000, wk ? AMP_POS : AMP_NEG};
         DATA:    bin_val = ram[b[7:0]];
         default: bin_val = '0;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state  <= FILL;
         f_w    <= F_FIRST;
         b      <= '0;
         last_q <= 1'b0;
         cyc_q  <= 1'b0;
         DAT_O  <= '0;
         STB_O  <= 1'b0;
         CYC_O  <= 1'b0;
      end else begin
         cyc_q <= CYC_I;
         case (state)
            FILL: begin
               if (!CYC_I)
                  f_w <= F_FIRST;
               else if (ACK_O) begin
                  if (f_w == F_LAST) begin
                     state <= DRAIN;
                     CYC_O <= 1'b1;
                     f_w   <= F_FIRST;
                  end else
                     f_w <= f_nxt;
               end
            end
            DRAIN: begin
               // b[8] marks all 256 bins issued; STB_O drops once bin 255 is taken.
               if (!halt) begin
                  DAT_O  <= bin_val;
                  STB_O  <= ~b[8];
                  last_q <= (b == 9'd255);
                  if (!b[8])
                     b <= b + 9'd1;
               end
               if (last_acc) begin
                  state <= FILL;
                  b     <= '0;
                  if (!CYC_I)
                     CYC_O <= 1'b0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end
endmodule
